// File: rtl/serial_pattern_gen_if.sv
// Bundle between a pattern-transmitter client and serial_pattern_gen.
// The master side requests transmissions; the slave side drives the serial line and status.
interface serial_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;   // "repeat" is a reserved word; extra passes beyond the first
    logic             out;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_cnt,
        input  out, busy, done
    );

    modport slave (
        input  start, abort, pattern, repeat_cnt,
        output out, busy, done
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial 1-bit pattern transmitter: sends a captured WIDTH-bit pattern MSB-first,
// back-to-back for repeat_cnt+1 passes, then pulses done for one cycle.
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    serial_pattern_gen_if.slave bus
);
    localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // DONE accepts a new start exactly like IDLE so a held start streams with one gap cycle.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    pat_d   = bus.pattern;
                    rep_d   = bus.repeat_cnt;
                    bit_d   = BIT_W'(WIDTH - 1);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                end else if (rep_q != '0) begin
                    rep_d = rep_q - 1'b1;
                    bit_d = BIT_W'(WIDTH - 1);
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a function of the next state so they appear registered on the same edge.
    always_comb begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            SHIFT: begin
                out_d  = pat_d[bit_d];
                busy_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Serial 1-bit pattern transmitter. It is the driving end of the single-bit `in` line that our sequence-detector FSMs (my_fsm family) sample. It captures a WIDTH-bit pattern and a repeat count on a start strobe. It then shifts the pattern out MSB-first, one bit per clock, back-to-back for repeat+1 passes, and pulses done at the end. Used as a stimulus source in detector benches and as the on-chip pattern driver for detector self-test.

Parameters:
WIDTH, 8, pattern length in bits (>=2)
CNT_W, 4, width of repeat-count input

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled on rising edge when not busy
pattern  in  WIDTH  bits to send, MSB first; captured on accepted start
repeat  in  CNT_W  extra passes; total passes = repeat+1; captured on accepted start
abort  in  1  synchronous cancel of an in-progress transmission
out  out  1  serial line (registered); idle level 0
busy  out  1  high while a transmission is in progress
done  out  1  one-cycle pulse after the last bit of the last pass

Behaviour:
- One clock: clock. Reset is asynchronous and active-high on port reset.
- Reset (async, any time, including mid-transmission): out=0, busy=0, done=0, state=IDLE. All counters are cleared. The registers holding the captured pattern and repeat count are cleared.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE: out=0, busy=0, done=0.
  - On an edge with start=1: capture pattern->pat_q and repeat->rep_cnt. Set bit_cnt=WIDTH-1, out<=pattern[WIDTH-1], busy<=1, state->SHIFT.
  - Accept edge = E0. Bit k of the stream is driven on out during the cycle after edge E0+k.
- SHIFT: on each edge, evaluated in priority order.
  - abort=1: out<=0, busy<=0, done<=0, state->IDLE. No done pulse.
  - bit_cnt>0: bit_cnt--, out<=next lower bit of the current pass.
  - bit_cnt==0 and rep_cnt>0: rep_cnt--, bit_cnt<=WIDTH-1, out<=pat_q[WIDTH-1]. The next pass begins with no gap cycle.
  - bit_cnt==0 and rep_cnt==0: out<=0, busy<=0, done<=1, state->DONE.
- Stream length: exactly WIDTH*(repeat+1) consecutive bit cycles. busy is high for exactly those cycles. The done pulse occurs in the cycle after the last bit.
- DONE (one cycle): done=1, busy=0, out=0.
  - start=1 on this edge is accepted exactly as in IDLE (new capture, state->SHIFT), and done drops.
  - Otherwise state->IDLE and done drops.
- start while in SHIFT is ignored. pattern and repeat changes while busy are ignored; pat_q and rep_cnt hold the captured values.
- abort in IDLE or DONE has no effect. If start=1 and abort=1 arrive in IDLE together, start wins (abort only affects SHIFT).
- repeat=0 means a single pass. repeat=all-ones means 2^CNT_W passes. There is no wrap or overflow because rep_cnt only decrements and stops at 0.

Test Plan:
1. WIDTH=8, reset released. Start with pattern=8'h18 (0001_1000), repeat=0 -> out=0,0,0,1,1,0,0,0 in the 8 cycles after E0. busy=1 for those 8 cycles. done=1 in cycle 9 only, then IDLE with out=0. A my_fsm instance on out raises its detect as specified.
2. pattern=8'hA5, repeat=2 -> 24-bit stream 10100101 repeated 3 times with no gaps. busy is high for 24 cycles. A single done pulse follows at cycle 25.
3. pattern=8'hFF, repeat=1 -> out held 1 for 16 consecutive cycles, then 0 with done=1. After edge E0, new start pulses with pattern=8'h00 during busy are ignored: the stream is unchanged and there is only one done pulse.
4. start held high continuously with pattern=8'h81, repeat=0 -> 10000001, done cycle, then the next 10000001 starts immediately. The done cycle is the only cycle with out=0 and busy=0 between passes.
5. abort=1 at the 4th bit of pattern=8'hF0 -> out=0 and busy=0 on the next edge. done is never asserted and the FSM is in IDLE. A following start sends a full pattern correctly.
6. reset asserted asynchronously mid-pass (between clock edges) -> out, busy and done go to 0 immediately, not waiting for the next clock edge. After release, no residual bits are sent until a new start.
